apple1_ps2_keyboard: RTL and testbench

- Converts the PS/2 keyboard stream from user_io (ps2_kbd_clk/ps2_kbd_data) into Apple-1 ASCII key codes.
- Sits directly upstream of the apple1 core's PIA keyboard port ($D010 data, $D011 bit7 ready). This moves all PS/2 handling out of the core.
- Receives and validates PS/2 frames, tracks modifier/break state, and translates set-2 scan codes to uppercase 7-bit ASCII.
- Buffers keys in a small FIFO, pops one per CPU read, and pulses for clear-screen and reset hotkeys.

---
 rtl/apple1_ps2_keyboard.sv | 259 +++++++++++++++++++++++++
 tb/tb_apple1_ps2_keyboard.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple1_ps2_keyboard.sv
// PS/2 set-2 keyboard receiver and Apple-1 ASCII translator with a small key FIFO.
// Valid/ready semantics on the CPU side: kbd_ready is the valid flag for kbd_data;
// a kbd_rd strobe while kbd_ready=1 consumes the head entry, and the next entry
// (or 0 when empty) is visible on the following cycle. kbd_rd while empty is ignored.
module apple1_ps2_keyboard #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 114545
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  input  logic       kbd_rd,
  output logic [6:0] kbd_data,
  output logic       kbd_ready,
  output logic       cls_pulse,
  output logic       reset_req,
  output logic       frame_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Two-stage synchronizers plus a delayed copy of the clock for edge detection.
  logic clk_s1_q, clk_s2_q, clk_prev_q, din_s1_q, din_s2_q;
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      din_s1_q   <= 1'b1;
      din_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      din_s1_q   <= ps2_din;
      din_s2_q   <= din_s1_q;
    end
  end

  logic fall_edge;
  assign fall_edge = clk_prev_q & ~clk_s2_q;

  // Receiver: shift register fills from the top, so after 10 edges
  // [7:0] is the data byte, [8] parity and [9] the stop bit.
  logic [1:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          frame_err_q, frame_err_d;

  // Receiver next-state: start detect, bit collection, timeout, frame check.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tmo_d       = tmo_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (fall_edge && !din_s2_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 4'd0;
        end
      end
      ST_SHIFT: begin
        if (fall_edge) begin
          shreg_d   = {din_s2_q, shreg_q[9:1]};
          tmo_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = ST_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if ((^shreg_q[8:0]) && shreg_q[9]) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = shreg_q[7:0];
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 10'd0;
      tmo_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tmo_q       <= tmo_d;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Scan code to {hit, ascii}. Letters ignore shift and honour ctrl; everything
  // else honours shift and has lowercase-range results folded down by 0x20.
  function automatic logic [7:0] translate(input logic [7:0] sc, input logic sh, input logic ct);
    logic       hit;
    logic [6:0] a;
    hit = 1'b1;
    case (sc)
      8'h1C: a = 7'h41;  8'h32: a = 7'h42;  8'h21: a = 7'h43;  8'h23: a = 7'h44;
      8'h24: a = 7'h45;  8'h2B: a = 7'h46;  8'h34: a = 7'h47;  8'h33: a = 7'h48;
      8'h43: a = 7'h49;  8'h3B: a = 7'h4A;  8'h42: a = 7'h4B;  8'h4B: a = 7'h4C;
      8'h3A: a = 7'h4D;  8'h31: a = 7'h4E;  8'h44: a = 7'h4F;  8'h4D: a = 7'h50;
      8'h15: a = 7'h51;  8'h2D: a = 7'h52;  8'h1B: a = 7'h53;  8'h2C: a = 7'h54;
      8'h3C: a = 7'h55;  8'h2A: a = 7'h56;  8'h1D: a = 7'h57;  8'h22: a = 7'h58;
      8'h35: a = 7'h59;  8'h1A: a = 7'h5A;
      default: a = 7'h00;
    endcase
    if (a != 7'h00) begin
      if (ct) a = a & 7'h1F;
    end else begin
      case (sc)
        8'h16: a = sh ? 7'h21 : 7'h31;  8'h1E: a = sh ? 7'h40 : 7'h32;
        8'h26: a = sh ? 7'h23 : 7'h33;  8'h25: a = sh ? 7'h24 : 7'h34;
        8'h2E: a = sh ? 7'h25 : 7'h35;  8'h36: a = sh ? 7'h5E : 7'h36;
        8'h3D: a = sh ? 7'h26 : 7'h37;  8'h3E: a = sh ? 7'h2A : 7'h38;
        8'h46: a = sh ? 7'h28 : 7'h39;  8'h45: a = sh ? 7'h29 : 7'h30;
        8'h4E: a = sh ? 7'h5F : 7'h2D;  8'h55: a = sh ? 7'h2B : 7'h3D;
        8'h54: a = sh ? 7'h7B : 7'h5B;  8'h5B: a = sh ? 7'h7D : 7'h5D;
        8'h4C: a = sh ? 7'h3A : 7'h3B;  8'h52: a = sh ? 7'h22 : 7'h27;
        8'h41: a = sh ? 7'h3C : 7'h2C;  8'h49: a = sh ? 7'h3E : 7'h2E;
        8'h4A: a = sh ? 7'h3F : 7'h2F;  8'h5D: a = sh ? 7'h7C : 7'h5C;
        8'h0E: a = sh ? 7'h7E : 7'h60;
        8'h5A: a = 7'h0D;  8'h29: a = 7'h20;  8'h76: a = 7'h1B;  8'h66: a = 7'h5F;
        default: hit = 1'b0;
      endcase
      if (a[6:5] == 2'b11) a[5] = 1'b0;
    end
    return {hit, a};
  endfunction

  logic       ext_q, ext_d, brk_q, brk_d, shift_q, shift_d, ctrl_q, ctrl_d;
  logic       cls_q, cls_d, rreq_q, rreq_d;
  logic       push;
  logic [6:0] push_data;
  logic [7:0] xl;

  // Decoder: prefix flags, modifier tracking and hotkeys, one byte per cycle.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    shift_d   = shift_q;
    ctrl_d    = ctrl_q;
    cls_d     = 1'b0;
    rreq_d    = 1'b0;
    push      = 1'b0;
    xl        = translate(rx_byte_q, shift_q, ctrl_q);
    push_data = xl[6:0];
    if (rx_valid_q) begin
      if (rx_byte_q == 8'hE0) ext_d = 1'b1;
      else if (rx_byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q && (rx_byte_q == 8'h12 || rx_byte_q == 8'h59)) shift_d = !brk_q;
        else if (rx_byte_q == 8'h14) ctrl_d = !brk_q;
        else if (!brk_q && !ext_q) begin
          if (rx_byte_q == 8'h05) cls_d = 1'b1;
          else if (rx_byte_q == 8'h07) rreq_d = 1'b1;
          else push = xl[7];
        end
      end
    end
  end

  // FIFO: registered array, head read combinationally.
  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [6:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          pop, wr_en;

  assign pop   = kbd_rd && (cnt_q != '0);
  assign wr_en = push && ((cnt_q != DEPTH_C) || pop);

  // FIFO next-state; a full FIFO still accepts a push when a pop frees the slot.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (wr_en) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Decoder and FIFO registers.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      cls_q   <= 1'b0;
      rreq_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 7'h00;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
      cls_q   <= cls_d;
      rreq_q  <= rreq_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign kbd_ready = (cnt_q != '0);
  assign kbd_data  = kbd_ready ? mem_q[rd_q] : 7'h00;
  assign cls_pulse = cls_q;
  assign reset_req = rreq_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_apple1_ps2_keyboard.sv
// Bench for apple1_ps2_keyboard: directed sequences, a vector table and
// randomized key streams checked against a map-based keyboard model.
module tb_apple1_ps2_keyboard;

  localparam int FIFO_DEPTH = 4;
  localparam int TMO        = 200;

  logic       sys_clock = 1'b0;
  logic       reset, ps2_clk, ps2_din, kbd_rd;
  logic [6:0] kbd_data;
  logic       kbd_ready, cls_pulse, reset_req, frame_err;

  apple1_ps2_keyboard #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clock(sys_clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_din(ps2_din),
    .kbd_rd(kbd_rd), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .cls_pulse(cls_pulse), .reset_req(reset_req), .frame_err(frame_err)
  );

  // Clock and watchdog.
  always #5 sys_clock = ~sys_clock;
  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pulse monitors: count rising edges and cycles where a pulse stayed high.
  int cls_rise = 0, cls_long = 0, rr_rise = 0, rr_long = 0, fe_rise = 0, fe_long = 0;
  logic cls_prev = 1'b0, rr_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge sys_clock) begin
    if (cls_pulse) begin if (cls_prev) cls_long++; else cls_rise++; end
    if (reset_req) begin if (rr_prev) rr_long++; else rr_rise++; end
    if (frame_err) begin if (fe_prev) fe_long++; else fe_rise++; end
    cls_prev = cls_pulse;
    rr_prev  = reset_req;
    fe_prev  = frame_err;
  end

  // Driver tasks.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit rd_at_push,
                            input bit lat_chk, input logic [6:0] lat_exp);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge sys_clock); ps2_din = fr[i];
      @(negedge sys_clock); ps2_clk = 1'b0;
      if (i == 10) begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge sys_clock);
          if (lat_chk && k == 4) check("latency_early_ready", kbd_ready, 0);
          if (lat_chk && k == 5) begin
            check("latency_ready", kbd_ready, 1);
            check("latency_data", kbd_data, lat_exp);
          end
          if (rd_at_push && k == 4) kbd_rd = 1'b1;
          if (rd_at_push && k == 5) kbd_rd = 1'b0;
        end
      end else begin
        repeat (4) @(negedge sys_clock);
      end
      ps2_clk = 1'b1;
      repeat (2) @(negedge sys_clock);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 7'h00);
  endtask

  task automatic send_bit(input logic b);
    @(negedge sys_clock); ps2_din = b;
    @(negedge sys_clock); ps2_clk = 1'b0;
    repeat (4) @(negedge sys_clock);
    ps2_clk = 1'b1;
    repeat (2) @(negedge sys_clock);
  endtask

  task automatic pop_check(input string name, input logic [6:0] exp);
    @(negedge sys_clock);
    check({name, "_ready"}, kbd_ready, 1);
    check({name, "_data"}, kbd_data, exp);
    kbd_rd = 1'b1;
    @(negedge sys_clock);
    kbd_rd = 1'b0;
  endtask

  task automatic expect_empty(input string name);
    @(negedge sys_clock);
    check({name, "_ready"}, kbd_ready, 0);
    check({name, "_data"}, kbd_data, 0);
  endtask

  // Reference model: character maps built from the key legends.
  logic [6:0] base_map  [logic [7:0]];
  logic [6:0] shift_map [logic [7:0]];
  bit         letter_map[logic [7:0]];
  logic [7:0] key_pool[$];
  logic [6:0] exp_q[$];
  bit m_ext = 0, m_brk = 0, m_shift = 0, m_ctrl = 0;
  int exp_cls = 0, exp_rr = 0;

  task automatic build_maps();
    string letters, digits, dshift;
    logic [6:0] punct [11];
    logic [6:0] pshift [11];
    logic [7:0] letter_sc [26];
    logic [7:0] digit_sc [10];
    logic [7:0] punct_sc [11];
    letters   = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    digits    = "1234567890";
    dshift    = "!@#$%^&*()";
    punct     = '{7'h2D, 7'h3D, 7'h5B, 7'h5D, 7'h3B, 7'h27, 7'h2C, 7'h2E, 7'h2F, 7'h5C, 7'h60};
    pshift    = '{7'h5F, 7'h2B, 7'h7B, 7'h7D, 7'h3A, 7'h22, 7'h3C, 7'h3E, 7'h3F, 7'h7C, 7'h7E};
    letter_sc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                  8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                  8'h35, 8'h1A};
    digit_sc  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    punct_sc  = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h5D, 8'h0E};
    for (int i = 0; i < 26; i++) begin
      base_map[letter_sc[i]]   = 7'(letters[i]);
      shift_map[letter_sc[i]]  = 7'(letters[i]);
      letter_map[letter_sc[i]] = 1'b1;
      key_pool.push_back(letter_sc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      base_map[digit_sc[i]]  = 7'(digits[i]);
      shift_map[digit_sc[i]] = 7'(dshift[i]);
      key_pool.push_back(digit_sc[i]);
    end
    for (int i = 0; i < 11; i++) begin
      base_map[punct_sc[i]]  = punct[i];
      shift_map[punct_sc[i]] = pshift[i];
      key_pool.push_back(punct_sc[i]);
    end
    base_map[8'h5A] = 7'h0D; shift_map[8'h5A] = 7'h0D; key_pool.push_back(8'h5A);
    base_map[8'h29] = 7'h20; shift_map[8'h29] = 7'h20; key_pool.push_back(8'h29);
    base_map[8'h76] = 7'h1B; shift_map[8'h76] = 7'h1B; key_pool.push_back(8'h76);
    base_map[8'h66] = 7'h5F; shift_map[8'h66] = 7'h5F; key_pool.push_back(8'h66);
    key_pool.push_back(8'h6B);
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [6:0] c;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
      else if (b == 8'h14) m_ctrl = !m_brk;
      else if (!m_ext && !m_brk) begin
        if (b == 8'h05) exp_cls++;
        else if (b == 8'h07) exp_rr++;
        else if (base_map.exists(b)) begin
          if (letter_map.exists(b)) c = m_ctrl ? (base_map[b] & 7'h1F) : base_map[b];
          else begin
            c = m_shift ? shift_map[b] : base_map[b];
            if (c >= 7'h60) c = c - 7'h20;
          end
          if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(c);
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_m(input logic [7:0] b);
    model_byte(b);
    send(b);
  endtask

  typedef struct {
    logic [7:0] sc;
    bit         sh;
    bit         ct;
    bit         hit;
    logic [6:0] asc;
    string      name;
  } vec_t;
  vec_t vecs [18];

  int b_cls, b_cls_l, b_rr, b_rr_l, b_fe, b_fe_l;

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_din = 1'b1; kbd_rd = 1'b0;
    build_maps();
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 7'h41, "vec_A"};
    vecs[1]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 7'h41, "vec_shift_A"};
    vecs[2]  = '{8'h34, 1'b0, 1'b1, 1'b1, 7'h07, "vec_ctrl_G"};
    vecs[3]  = '{8'h16, 1'b1, 1'b0, 1'b1, 7'h21, "vec_shift_1"};
    vecs[4]  = '{8'h1E, 1'b1, 1'b0, 1'b1, 7'h40, "vec_shift_2"};
    vecs[5]  = '{8'h45, 1'b0, 1'b0, 1'b1, 7'h30, "vec_digit_0"};
    vecs[6]  = '{8'h4E, 1'b1, 1'b0, 1'b1, 7'h5F, "vec_underscore"};
    vecs[7]  = '{8'h54, 1'b1, 1'b0, 1'b1, 7'h5B, "vec_lbrace_fold"};
    vecs[8]  = '{8'h0E, 1'b0, 1'b0, 1'b1, 7'h40, "vec_backtick_fold"};
    vecs[9]  = '{8'h0E, 1'b1, 1'b0, 1'b1, 7'h5E, "vec_tilde_fold"};
    vecs[10] = '{8'h52, 1'b1, 1'b0, 1'b1, 7'h22, "vec_dquote"};
    vecs[11] = '{8'h5A, 1'b0, 1'b0, 1'b1, 7'h0D, "vec_enter"};
    vecs[12] = '{8'h29, 1'b0, 1'b0, 1'b1, 7'h20, "vec_space"};
    vecs[13] = '{8'h76, 1'b0, 1'b0, 1'b1, 7'h1B, "vec_esc"};
    vecs[14] = '{8'h66, 1'b0, 1'b0, 1'b1, 7'h5F, "vec_backspace"};
    vecs[15] = '{8'h5D, 1'b1, 1'b0, 1'b1, 7'h5C, "vec_pipe_fold"};
    vecs[16] = '{8'h4A, 1'b1, 1'b0, 1'b1, 7'h3F, "vec_question"};
    vecs[17] = '{8'h6B, 1'b0, 1'b0, 1'b0, 7'h00, "vec_unmapped"};

    // Reset state.
    repeat (3) @(negedge sys_clock);
    check("reset_ready", kbd_ready, 0);
    check("reset_data", kbd_data, 0);
    check("reset_cls", cls_pulse, 0);
    check("reset_rreq", reset_req, 0);
    check("reset_ferr", frame_err, 0);
    reset = 1'b0;
    repeat (3) @(negedge sys_clock);

    // 'A' make with exact latency, then one read empties the FIFO.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 7'h41);
    pop_check("t1_pop", 7'h41);
    expect_empty("t1_after_pop");

    // Shifted and unshifted '1'.
    send(8'h12); send(8'h16); send(8'hF0); send(8'h16); send(8'hF0); send(8'h12); send(8'h16);
    pop_check("t2_bang", 7'h21);
    pop_check("t2_one", 7'h31);
    expect_empty("t2_empty");

    // Bad parity frame is rejected, next frame is fine.
    b_fe = fe_rise; b_fe_l = fe_long;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 7'h00);
    check("t3_ferr_count", fe_rise - b_fe, 1);
    check("t3_ferr_width", fe_long - b_fe_l, 0);
    check("t3_ready", kbd_ready, 0);
    send(8'h5A);
    pop_check("t3_enter", 7'h0D);
    expect_empty("t3_empty");

    // Overflow drops newest keys; push with pop at full keeps order.
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24); send(8'h2B);
    pop_check("t4_a", 7'h41); pop_check("t4_b", 7'h42);
    pop_check("t4_c", 7'h43); pop_check("t4_d", 7'h44);
    expect_empty("t4_empty");
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    send_frame(8'h24, 1'b0, 1'b1, 1'b0, 7'h00);
    send(8'h2B);
    pop_check("t4s_b", 7'h42); pop_check("t4s_c", 7'h43);
    pop_check("t4s_d", 7'h44); pop_check("t4s_e", 7'h45);
    expect_empty("t4s_empty");

    // Partial frame abandoned by timeout.
    b_fe = fe_rise;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (TMO + 20) @(negedge sys_clock);
    send(8'h29);
    pop_check("t5_space", 7'h20);
    check("t5_no_ferr", fe_rise - b_fe, 0);
    expect_empty("t5_empty");

    // Vector table.
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].sh) send(8'h12);
      if (vecs[i].ct) send(8'h14);
      send(vecs[i].sc);
      send(8'hF0); send(vecs[i].sc);
      if (vecs[i].sh) begin send(8'hF0); send(8'h12); end
      if (vecs[i].ct) begin send(8'hF0); send(8'h14); end
      if (vecs[i].hit) pop_check(vecs[i].name, vecs[i].asc);
      else check({vecs[i].name, "_none"}, kbd_ready, 0);
    end

    // Hotkeys and ctrl+G.
    b_cls = cls_rise; b_cls_l = cls_long; b_rr = rr_rise; b_rr_l = rr_long;
    send(8'h05); send(8'hF0); send(8'h05);
    check("t6_cls_count", cls_rise - b_cls, 1);
    check("t6_cls_width", cls_long - b_cls_l, 0);
    send(8'h07); send(8'hF0); send(8'h07);
    check("t6_rreq_count", rr_rise - b_rr, 1);
    check("t6_rreq_width", rr_long - b_rr_l, 0);
    check("t6_no_key", kbd_ready, 0);
    send(8'h14); send(8'h34); send(8'hF0); send(8'h34); send(8'hF0); send(8'h14);
    pop_check("t6_ctrl_g", 7'h07);
    expect_empty("t6_empty");

    // Reset in the middle of a frame with a key buffered.
    send(8'h1C);
    check("t6r_pre_ready", kbd_ready, 1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge sys_clock); reset = 1'b1;
    @(negedge sys_clock);
    check("t6r_ready", kbd_ready, 0);
    check("t6r_data", kbd_data, 0);
    check("t6r_cls", cls_pulse, 0);
    check("t6r_rreq", reset_req, 0);
    check("t6r_ferr", frame_err, 0);
    reset = 1'b0;
    repeat (3) @(negedge sys_clock);
    send(8'h1B);
    pop_check("t6r_after", 7'h53);
    expect_empty("t6r_empty");

    // Randomized key streams against the model.
    b_cls = cls_rise; b_rr = rr_rise; b_fe = fe_rise;
    exp_cls = 0; exp_rr = 0;
    for (int round = 0; round < 20; round++) begin
      int n_ev, n_exp, n_got;
      n_ev = $urandom_range(1, 5);
      for (int e = 0; e < n_ev; e++) begin
        int r;
        logic [7:0] k;
        r = $urandom_range(0, 19);
        if (r < 3) begin
          case ($urandom_range(0, 2))
            0: k = 8'h12;
            1: k = 8'h59;
            default: k = 8'h14;
          endcase
          if (k == 8'h14 && $urandom_range(0, 1) == 1) send_m(8'hE0);
          if ($urandom_range(0, 1) == 1) send_m(8'hF0);
          send_m(k);
        end else if (r == 3) begin
          send_m(8'hE0);
          if ($urandom_range(0, 1) == 1) send_m(8'hF0);
          send_m(8'h75);
        end else if (r == 4) begin
          send_m(($urandom_range(0, 1) == 1) ? 8'h05 : 8'h07);
        end else begin
          k = key_pool[$urandom_range(0, key_pool.size() - 1)];
          if ($urandom_range(0, 3) == 0) send_m(8'hF0);
          send_m(k);
        end
      end
      n_exp = exp_q.size();
      n_got = 0;
      for (int g = 0; g < FIFO_DEPTH + 2; g++) begin
        logic [6:0] ev;
        @(negedge sys_clock);
        if (!kbd_ready) break;
        ev = 7'h7F;
        if (exp_q.size() > 0) ev = exp_q.pop_front();
        check("rand_key", kbd_data, ev);
        kbd_rd = 1'b1;
        @(negedge sys_clock);
        kbd_rd = 1'b0;
        n_got++;
      end
      check("rand_count", n_got, n_exp);
      exp_q.delete();
    end
    check("rand_cls", cls_rise - b_cls, exp_cls);
    check("rand_rreq", rr_rise - b_rr, exp_rr);
    check("rand_ferr", fe_rise - b_fe, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
